// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: FSM state encoding,
// instruction size, default trap entry point and next-PC source selector.
package mips_pkg;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TRAP = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    localparam int          INSTR_BYTES    = 4;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

    // Where the next PC comes from; HOLD keeps the current value.
    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_SEQ,
        SRC_BRANCH,
        SRC_JUMP,
        SRC_JREG,
        SRC_EXC,
        SRC_EPC
    } pc_src_e;

    // A byte address is a legal fetch target only on a word boundary.
    function automatic logic word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect requests into the PC sequencer and fetch-side status out of it.
interface pc_sequencer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  Stall;
    logic                  Branch_Taken;
    logic [ADDR_WIDTH-1:0] Branch_Offset;
    logic                  Jump;
    logic [25:0]           Jump_Index;
    logic                  Jump_Reg;
    logic [ADDR_WIDTH-1:0] Jump_Reg_Target;
    logic                  Exception;
    logic                  Eret;
    logic                  Halt;
    logic                  Resume;

    logic [ADDR_WIDTH-1:0] PC;
    logic [ADDR_WIDTH-1:0] PC_Plus4;
    logic                  PC_Valid;
    logic [ADDR_WIDTH-1:0] EPC;
    logic                  Misaligned;
    logic [1:0]            State;

    // Requesters (decode/execute/exception unit) drive redirects.
    modport master (
        output Stall, Branch_Taken, Branch_Offset, Jump, Jump_Index,
               Jump_Reg, Jump_Reg_Target, Exception, Eret, Halt, Resume,
        input  PC, PC_Plus4, PC_Valid, EPC, Misaligned, State
    );

    // The sequencer consumes redirects and publishes the fetch PC.
    modport slave (
        input  Stall, Branch_Taken, Branch_Offset, Jump, Jump_Index,
               Jump_Reg, Jump_Reg_Target, Exception, Eret, Halt, Resume,
        output PC, PC_Plus4, PC_Valid, EPC, Misaligned, State
    );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC computation: target arithmetic plus the
// priority decode of redirect requests for the current FSM state.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = ADDR_WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic [1:0]            state_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [ADDR_WIDTH-1:0] epc_i,
    input  logic                  stall_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] branch_offset_i,
    input  logic                  jump_i,
    input  logic [25:0]           jump_index_i,
    input  logic                  jump_reg_i,
    input  logic [ADDR_WIDTH-1:0] jump_reg_target_i,
    input  logic                  exception_i,
    input  logic                  eret_i,
    input  logic                  halt_i,
    input  logic                  resume_i,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o,
    output logic [ADDR_WIDTH-1:0] next_pc_o,
    output logic                  take_trap_o,
    output logic                  misaligned_o,
    output logic                  enter_halt_o,
    output logic                  leave_halt_o
);

    pc_src_e               src;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic                  jr_bad;

    // Sequential and relative targets all wrap modulo 2^ADDR_WIDTH.
    assign pc_plus4_o    = pc_i + ADDR_WIDTH'(INSTR_BYTES);
    assign branch_target = pc_plus4_o + (branch_offset_i << 2);
    assign jump_target   = {pc_plus4_o[ADDR_WIDTH-1:28], jump_index_i, 2'b00};
    assign jr_bad        = jump_reg_i && !word_aligned(jump_reg_target_i[1:0]);

    // Priority decode; only RUN honours ordinary redirects, HALT only
    // reacts to Exception/Resume, BOOT and TRAP ignore everything.
    always_comb begin
        src          = SRC_HOLD;
        take_trap_o  = 1'b0;
        misaligned_o = 1'b0;
        enter_halt_o = 1'b0;
        leave_halt_o = 1'b0;
        case (state_i)
            ST_RUN: begin
                if (exception_i) begin
                    src         = SRC_EXC;
                    take_trap_o = 1'b1;
                end else if (jr_bad) begin
                    src          = SRC_EXC;
                    take_trap_o  = 1'b1;
                    misaligned_o = 1'b1;
                end else if (eret_i) begin
                    src = SRC_EPC;
                end else if (halt_i) begin
                    enter_halt_o = 1'b1;
                end else if (stall_i) begin
                    src = SRC_HOLD;
                end else if (jump_reg_i) begin
                    src = SRC_JREG;
                end else if (jump_i) begin
                    src = SRC_JUMP;
                end else if (branch_taken_i) begin
                    src = SRC_BRANCH;
                end else begin
                    src = SRC_SEQ;
                end
            end
            ST_HALT: begin
                if (exception_i) begin
                    src         = SRC_EXC;
                    take_trap_o = 1'b1;
                end else if (resume_i) begin
                    leave_halt_o = 1'b1;
                end
            end
            default: src = SRC_HOLD;
        endcase
    end

    // Map the selected source onto an address.
    always_comb begin
        next_pc_o = pc_i;
        case (src)
            SRC_SEQ:    next_pc_o = pc_plus4_o;
            SRC_BRANCH: next_pc_o = branch_target;
            SRC_JUMP:   next_pc_o = jump_target;
            SRC_JREG:   next_pc_o = jump_reg_target_i;
            SRC_EXC:    next_pc_o = EXC_VECTOR;
            SRC_EPC:    next_pc_o = epc_i;
            default:    next_pc_o = pc_i;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter: PC/EPC registers, boot/run/trap/halt FSM and
// the misaligned-JR pulse. Target selection lives in pc_next_mux.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,  // must be >= 32
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(32'h0000_0000),
    parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = ADDR_WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic           CLK,
    input  logic           RST,
    pc_sequencer_if.slave  bus
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] epc_q, epc_d;
    logic [1:0]            state_q, state_d;
    logic                  mis_q, mis_d;

    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  take_trap;
    logic                  misaligned;
    logic                  enter_halt;
    logic                  leave_halt;

    pc_next_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next (
        .state_i           (state_q),
        .pc_i              (pc_q),
        .epc_i             (epc_q),
        .stall_i           (bus.Stall),
        .branch_taken_i    (bus.Branch_Taken),
        .branch_offset_i   (bus.Branch_Offset),
        .jump_i            (bus.Jump),
        .jump_index_i      (bus.Jump_Index),
        .jump_reg_i        (bus.Jump_Reg),
        .jump_reg_target_i (bus.Jump_Reg_Target),
        .exception_i       (bus.Exception),
        .eret_i            (bus.Eret),
        .halt_i            (bus.Halt),
        .resume_i          (bus.Resume),
        .pc_plus4_o        (pc_plus4),
        .next_pc_o         (next_pc),
        .take_trap_o       (take_trap),
        .misaligned_o      (misaligned),
        .enter_halt_o      (enter_halt),
        .leave_halt_o      (leave_halt)
    );

    // Next-state logic: BOOT and TRAP last one cycle; traps capture the
    // address of the fetch that faulted.
    always_comb begin
        state_d = state_q;
        pc_d    = next_pc;
        epc_d   = take_trap ? pc_q : epc_q;
        mis_d   = misaligned;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (take_trap)       state_d = ST_TRAP;
                else if (enter_halt) state_d = ST_HALT;
            end
            ST_TRAP: state_d = ST_RUN;
            ST_HALT: begin
                if (take_trap)       state_d = ST_TRAP;
                else if (leave_halt) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State registers; reset overrides any request on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            state_q <= ST_BOOT;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            state_q <= state_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.PC         = pc_q;
    assign bus.PC_Plus4   = pc_plus4;
    assign bus.EPC        = epc_q;
    assign bus.Misaligned = mis_q;
    assign bus.State      = state_q;
    assign bus.PC_Valid   = (state_q == ST_RUN) && !bus.Stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the driver queues the expected
// post-edge view with each vector, a monitor checks it after the edge.
module tb_pc_sequencer;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;

    pc_sequencer_if #(.ADDR_WIDTH(32)) bus ();

    pc_sequencer #(
        .ADDR_WIDTH   (32),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h0000_0080)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        v;
        logic        m;
        logic [1:0]  st;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Monitor: one expected entry per clock edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            if (bus.PC !== e.pc || bus.PC_Plus4 !== e.pc + 32'd4 ||
                bus.EPC !== e.epc || bus.PC_Valid !== e.v ||
                bus.Misaligned !== e.m || bus.State !== e.st) begin
                n_bad++;
                $display("FAIL %s: got pc=%h epc=%h valid=%b mis=%b st=%0d plus4=%h, expected pc=%h epc=%h valid=%b mis=%b st=%0d",
                         e.nm, bus.PC, bus.EPC, bus.PC_Valid, bus.Misaligned, bus.State,
                         bus.PC_Plus4, e.pc, e.epc, e.v, e.m, e.st);
            end else begin
                $display("vec %-12s pc=%h epc=%h valid=%b mis=%b st=%0d", e.nm,
                         bus.PC, bus.EPC, bus.PC_Valid, bus.Misaligned, bus.State);
            end
        end
    end

    task automatic idle();
        rst                 = 1'b0;
        bus.Stall           = 1'b0;
        bus.Branch_Taken    = 1'b0;
        bus.Branch_Offset   = '0;
        bus.Jump            = 1'b0;
        bus.Jump_Index      = '0;
        bus.Jump_Reg        = 1'b0;
        bus.Jump_Reg_Target = '0;
        bus.Exception       = 1'b0;
        bus.Eret            = 1'b0;
        bus.Halt            = 1'b0;
        bus.Resume          = 1'b0;
    endtask

    // Called at a falling edge with inputs already set; queues the
    // expectation for the next rising edge, then clears the inputs.
    task automatic step(input string nm, input logic [31:0] pc, input logic [31:0] epc,
                        input logic v, input logic m, input logic [1:0] st);
        exp_t e;
        e.nm = nm; e.pc = pc; e.epc = epc; e.v = v; e.m = m; e.st = st;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic jr(input logic [31:0] t);
        bus.Jump_Reg = 1'b1; bus.Jump_Reg_Target = t;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);

        // reset and free run
        rst = 1'b1;                          step("reset",    32'h0,   32'h0, 0, 0, ST_BOOT);
                                             step("boot",     32'h0,   32'h0, 1, 0, ST_RUN);
                                             step("seq4",     32'h4,   32'h0, 1, 0, ST_RUN);
                                             step("seq8",     32'h8,   32'h0, 1, 0, ST_RUN);
                                             step("seqC",     32'hC,   32'h0, 1, 0, ST_RUN);
        // branches and jump
        jr(32'h100);                         step("jr100",    32'h100, 32'h0, 1, 0, ST_RUN);
        bus.Branch_Taken = 1'b1; bus.Branch_Offset = 32'hFFFF_FFFE;
                                             step("br_m2",    32'hFC,  32'h0, 1, 0, ST_RUN);
        jr(32'h100);                         step("jr100b",   32'h100, 32'h0, 1, 0, ST_RUN);
        bus.Branch_Taken = 1'b1; bus.Branch_Offset = 32'h3;
                                             step("br_p3",    32'h110, 32'h0, 1, 0, ST_RUN);
        jr(32'h100);                         step("jr100c",   32'h100, 32'h0, 1, 0, ST_RUN);
        bus.Jump = 1'b1; bus.Jump_Index = 26'h40;
                                             step("jump40",   32'h100, 32'h0, 1, 0, ST_RUN);
        jr(32'hFFFF_FFFC);                   step("jr_top",   32'hFFFF_FFFC, 32'h0, 1, 0, ST_RUN);
                                             step("wrap",     32'h0,   32'h0, 1, 0, ST_RUN);
        // misaligned JR, trap bubble, Eret
        jr(32'h200);                         step("jr200",    32'h200, 32'h0,   1, 0, ST_RUN);
        jr(32'h302);                         step("jr_mis",   32'h80,  32'h200, 0, 1, ST_TRAP);
                                             step("trap_out", 32'h80,  32'h200, 1, 0, ST_RUN);
        bus.Eret = 1'b1;                     step("eret",     32'h200, 32'h200, 1, 0, ST_RUN);
        // exception under stall, then plain stall
        jr(32'h40);                          step("jr40",     32'h40,  32'h200, 1, 0, ST_RUN);
        bus.Stall = 1'b1; bus.Exception = 1'b1;
                                             step("exc_stall",32'h80,  32'h40, 0, 0, ST_TRAP);
                                             step("trap_out2",32'h80,  32'h40, 1, 0, ST_RUN);
        jr(32'h40);                          step("jr40b",    32'h40,  32'h40, 1, 0, ST_RUN);
        for (int i = 0; i < 3; i++) begin
            bus.Stall = 1'b1;                step("stall",    32'h40,  32'h40, 0, 0, ST_RUN);
        end
        // halt / resume
        jr(32'h20);                          step("jr20",     32'h20,  32'h40, 1, 0, ST_RUN);
        bus.Halt = 1'b1;                     step("halt",     32'h20,  32'h40, 0, 0, ST_HALT);
        bus.Jump = 1'b1; bus.Jump_Index = 26'h123;
                                             step("halt_jmp", 32'h20,  32'h40, 0, 0, ST_HALT);
        bus.Eret = 1'b1;                     step("halt_eret",32'h20,  32'h40, 0, 0, ST_HALT);
        bus.Resume = 1'b1;                   step("resume",   32'h20,  32'h40, 1, 0, ST_RUN);
                                             step("seq24",    32'h24,  32'h40, 1, 0, ST_RUN);
        bus.Halt = 1'b1;                     step("halt2",    32'h24,  32'h40, 0, 0, ST_HALT);
        bus.Exception = 1'b1;                step("halt_exc", 32'h80,  32'h24, 0, 0, ST_TRAP);
        bus.Jump = 1'b1; bus.Jump_Index = 26'h10;
                                             step("trap_jmp", 32'h80,  32'h24, 1, 0, ST_RUN);
        bus.Halt = 1'b1;                     step("halt3",    32'h80,  32'h24, 0, 0, ST_HALT);
        rst = 1'b1; bus.Exception = 1'b1;    step("halt_rst", 32'h0,   32'h0,  0, 0, ST_BOOT);
        bus.Exception = 1'b1;                step("boot_exc", 32'h0,   32'h0,  1, 0, ST_RUN);
        // priority corners
        bus.Jump = 1'b1; bus.Jump_Index = 26'h40;
        bus.Branch_Taken = 1'b1; bus.Branch_Offset = 32'h3;
                                             step("jmp>br",   32'h100, 32'h0,  1, 0, ST_RUN);
        jr(32'h300); bus.Jump = 1'b1; bus.Jump_Index = 26'h10;
                                             step("jr>jmp",   32'h300, 32'h0,  1, 0, ST_RUN);
        jr(32'h301); bus.Exception = 1'b1;   step("exc>mis",  32'h80,  32'h300, 0, 0, ST_TRAP);
                                             step("trap_out3",32'h80,  32'h300, 1, 0, ST_RUN);
        bus.Halt = 1'b1; bus.Stall = 1'b1;   step("halt>stl", 32'h80,  32'h300, 0, 0, ST_HALT);
        bus.Resume = 1'b1; bus.Stall = 1'b1; step("res_stl",  32'h80,  32'h300, 0, 0, ST_RUN);
                                             step("seq84",    32'h84,  32'h300, 1, 0, ST_RUN);

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
